// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment character decoder:
// active-low segment patterns (bit0=a .. bit6=g) for each decodable
// character, the blank pattern, and the decoder FSM state type.
package seg7_pkg;

    localparam logic [6:0] PAT_0 = 7'h40;
    localparam logic [6:0] PAT_1 = 7'h79;
    localparam logic [6:0] PAT_2 = 7'h24;
    localparam logic [6:0] PAT_3 = 7'h30;
    localparam logic [6:0] PAT_4 = 7'h19;
    localparam logic [6:0] PAT_5 = 7'h12;
    localparam logic [6:0] PAT_6 = 7'h02;
    localparam logic [6:0] PAT_7 = 7'h78;
    localparam logic [6:0] PAT_8 = 7'h00;
    localparam logic [6:0] PAT_9 = 7'h18;
    localparam logic [6:0] PAT_B = 7'h38;
    localparam logic [6:0] PAT_C = 7'h09;
    localparam logic [6:0] PAT_D = 7'h1A;

    // All segments off: display is dark, nothing to decode.
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {
        TRACK    = 2'd0,
        EMIT     = 2'd1,
        WAIT_CHG = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_pattern_lut.sv
// Combinational segment-pattern to character-code lookup.
// Unknown patterns map to code 0 with err set; the blank pattern maps to
// code 0 without err (the caller never emits it).
module seg7_pattern_lut
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] code_o,
    output logic       err_o
);

    // Table lookup; anything not listed is an error pattern.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        code_o = 4'd0;
        err_o  = 1'b1;
        case (pat_i)
            PAT_0:   begin code_o = 4'd0;  err_o = 1'b0; end
            PAT_1:   begin code_o = 4'd1;  err_o = 1'b0; end
            PAT_2:   begin code_o = 4'd2;  err_o = 1'b0; end
            PAT_3:   begin code_o = 4'd3;  err_o = 1'b0; end
            PAT_4:   begin code_o = 4'd4;  err_o = 1'b0; end
            PAT_5:   begin code_o = 4'd5;  err_o = 1'b0; end
            PAT_6:   begin code_o = 4'd6;  err_o = 1'b0; end
            PAT_7:   begin code_o = 4'd7;  err_o = 1'b0; end
            PAT_8:   begin code_o = 4'd8;  err_o = 1'b0; end
            PAT_9:   begin code_o = 4'd9;  err_o = 1'b0; end
            PAT_B:   begin code_o = 4'd11; err_o = 1'b0; end
            PAT_C:   begin code_o = 4'd12; err_o = 1'b0; end
            PAT_D:   begin code_o = 4'd13; err_o = 1'b0; end
            BLANK:   begin code_o = 4'd0;  err_o = 1'b0; end
            default: begin code_o = 4'd0;  err_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_char_decoder.sv
// Seven-segment character decoder with input debouncing and a
// valid/ready result handshake.
//
// A segment pattern must be seen unchanged on STABLE_CYCLES+1 consecutive
// rising edges before it is decoded and offered on code_out/code_err with
// code_valid. After the consumer accepts it, the same pattern is not offered
// again until the input has moved away from it.
//
// Optional feature: define SEG7_DEC_ERRCNT_EN to add the err_count output,
// a saturating count of accepted results that had code_err set.
module seg7_char_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [6:0]           seg_in,
    output logic [3:0]           code_out,
    output logic                 code_err,
    output logic                 code_valid,
    input  logic                 code_ready
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

    state_e     state_q, state_d;
    logic [6:0] seg_q;
    logic [3:0] stab_cnt_q, stab_cnt_d;
    logic [3:0] code_q, code_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;
    logic [6:0] pat_q, pat_d;
    logic [6:0] last_pat_q, last_pat_d;
    logic       accept;
    logic [3:0] lut_code;
    logic       lut_err;

    seg7_pattern_lut u_lut (
        .pat_i  (seg_q),
        .code_o (lut_code),
        .err_o  (lut_err)
    );

    // Run length of the current input pattern, saturating at STABLE_CYCLES.
    always_comb begin
        stab_cnt_d = 4'd0;
        if (seg_in == seg_q) begin
            stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 4'd1;
        end
    end

    // Next-state and result logic: emit once stable, hold until accepted,
    // then wait for the input to leave the accepted pattern.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        err_d      = err_q;
        valid_d    = valid_q;
        pat_d      = pat_q;
        last_pat_d = last_pat_q;
        accept     = 1'b0;
        case (state_q)
            TRACK: begin
                // stab_cnt_d == STAB_MAX implies seg_in == seg_q this cycle.
                if (stab_cnt_d == STAB_MAX && seg_q != BLANK) begin
                    state_d = EMIT;
                    code_d  = lut_code;
                    err_d   = lut_err;
                    valid_d = 1'b1;
                    pat_d   = seg_q;
                end
            end
            EMIT: begin
                if (valid_q && code_ready) begin
                    accept     = 1'b1;
                    state_d    = WAIT_CHG;
                    valid_d    = 1'b0;
                    last_pat_d = pat_q;
                end
            end
            WAIT_CHG: begin
                if (seg_q != last_pat_q) begin
                    state_d = TRACK;
                end
            end
            default: begin
                state_d = TRACK;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state_q    <= TRACK;
            seg_q      <= BLANK;
            stab_cnt_q <= 4'd0;
            code_q     <= 4'd0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            pat_q      <= BLANK;
            last_pat_q <= BLANK;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_in;
            stab_cnt_q <= stab_cnt_d;
            code_q     <= code_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            pat_q      <= pat_d;
            last_pat_q <= last_pat_d;
        end
    end

    assign code_out   = code_q;
    assign code_err   = err_q;
    assign code_valid = valid_q;

`ifdef SEG7_DEC_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Count accepted error results, sticking at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && err_q && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
